vend_credit_fsm: RTL and testbench
==================================

# vend_credit_fsm

Parametrised successor to the per-item fixed-price vending FSMs. One credit register, one state machine and a price table serve `NUM_ITEMS` items. The block also accepts quarters, pays change of any size one nickel per cycle, supports cancel/refund, and can optionally track per-item stock. It sits between the coin-mechanism front end and the dispenser/change-hopper drivers.

## Interface
- `NUM_ITEMS`, 4: number of selectable items, 1..8.
- `BASE_PRICE`, 3: price of item 0, in nickels (3 = 15c).
- `PRICE_STEP`, 1: price increment per item index, in nickels. price(i) = BASE_PRICE + i*PRICE_STEP.
- `CREDIT_W`, 4: credit register width. Must satisfy 2^CREDIT_W > max price + 4.
- `STOCK_W`, 4: stock counter width (only used with VEND_STOCK_EN).
- `STOCK_INIT`, 10: stock value of every item at reset.

Ports:
- `clock` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `item_number` in NUM_ITEMS: one-hot item select. Sampled only on the first accepted coin of a transaction.
- `nickel_in`, `dime_in`, `quarter_in` in 1 each: one-cycle coin pulses.
- `cancel` in 1: one-cycle pulse that requests a refund of the current credit.
- `restock` in 1: one-cycle pulse that sets every stock counter to STOCK_INIT.
- `coin_ready` out 1: high in IDLE and COLLECT only.
- `dispense` out 1: one-cycle pulse that releases the selected item.
- `nickel_out` out 1: one-cycle pulse per nickel returned.
- `credit` out CREDIT_W: current credit in nickels.
- `sold_out` out NUM_ITEMS: per-item flag, set when stock of that item is 0.

## Operation
- States: IDLE, COLLECT, VEND, CHANGE.
- Coin value: nickel = 1, dime = 2, quarter = 5 (nickel units).
- Simultaneous coin pulses: only the highest value is accepted (quarter > dime > nickel). The others are dropped.
- Coins pulsed while `coin_ready` = 0 are dropped; credit does not change.
- IDLE + coin:
  - Latch `item_number` into `sel`.
  - If `item_number` is not one-hot, or the selected item is sold out: refund = coin value, go to CHANGE. No dispense.
  - Otherwise credit = coin value. If credit >= price(sel), go to VEND; else go to COLLECT.
- COLLECT + coin: credit += coin. If the new credit >= price(sel), go to VEND.
- COLLECT + cancel: refund = credit (including any coin accepted in the same cycle), go to CHANGE.
- Cancel has priority over the vend decision in that cycle.
- Cancel in IDLE, VEND or CHANGE is ignored.
- VEND (exactly one cycle):
  - `dispense` = 1.
  - Stock[sel] decrements.
  - refund = credit − price(sel).
  - Go to CHANGE if refund > 0, else go to IDLE.
  - credit clears to 0 on exit.
- CHANGE:
  - `nickel_out` = 1 every cycle and refund decrements each cycle.
  - On the cycle refund reaches 1 → exit to IDLE; credit is 0.
- `item_number` changes after the first coin are ignored until IDLE.
- Credit never overflows, given the CREDIT_W constraint.

## Timing
- Reset values:
  - State IDLE; credit 0; refund 0; sel 0.
  - `dispense` = 0, `nickel_out` = 0, `coin_ready` = 1.
  - Stock = STOCK_INIT; `sold_out` = 0.
- Reset mid-transaction abandons credit and refund with no pulses emitted. Reset has priority over every input.
- All outputs are registered.
  - A coin at edge N is reflected in `credit` after edge N.
  - If that coin completes the price, `dispense` is high in cycle N+1.
  - Change pulses are high in cycles N+2 .. N+1+refund.
  - `coin_ready` falls in cycle N+1.
- Refund without vend: `nickel_out` is high starting the cycle after the cancel or rejected coin.
- `restock` is applied at any time. If it coincides with the VEND decrement, restock wins.

## Configuration
- `VEND_STOCK_EN` defined:
  - Stock counters, `sold_out` and `restock` are active.
  - Stock saturates at 0.
  - A sold-out selection is refunded as described under Operation.
- `VEND_STOCK_EN` undefined:
  - No stock registers are built.
  - `sold_out` is tied to 0 and `restock` is ignored.
  - Every item is always available.

## Test plan
- Item 0 (15c), dime then nickel → `dispense` in the cycle after the nickel; zero `nickel_out` pulses; credit 0 and back in IDLE two cycles after the nickel.
- Item 0, quarter then dime (credit 25c ≥ 15c at the quarter) → `dispense` one cycle after the quarter; exactly 2 `nickel_out` pulses; the dime is dropped (`coin_ready` = 0).
- Item 3 (30c), dime, then cancel and nickel in the same cycle → 3 consecutive `nickel_out` pulses, no `dispense`, credit 0.
- `item_number` = 4'b0011 with a quarter → 5 `nickel_out` pulses, no `dispense`.
- Nickel, dime and quarter asserted together with item 1 (20c) selected → only the quarter is credited; `dispense` plus 1 `nickel_out` pulse.
- With `VEND_STOCK_EN` and STOCK_INIT = 1: buy item 2 twice → first purchase dispenses and `sold_out`[2] = 1; second quarter is refunded as 5 nickels. After `restock`, `sold_out`[2] = 0.

Source files
------------

// File: rtl/vend_credit_fsm.sv
// Multi-item vending controller: credit accumulation, cancel/refund and one-nickel-per-cycle change.
// Optional per-item stock tracking (counters, sold_out, restock) is built when VEND_STOCK_EN is defined.
module vend_credit_fsm #(
  parameter int NUM_ITEMS  = 4,
  parameter int BASE_PRICE = 3,
  parameter int PRICE_STEP = 1,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_ITEMS-1:0] item_number,
  input  logic                 nickel_in,
  input  logic                 dime_in,
  input  logic                 quarter_in,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 coin_ready,
  output logic                 dispense,
  output logic                 nickel_out,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] sold_out
);
  localparam int SEL_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t              state;
  logic [CREDIT_W-1:0] refund;
  logic [SEL_W-1:0]    sel;

  logic [CREDIT_W-1:0] coin_val;
  logic                coin_seen;
  logic                item_onehot;
  logic [SEL_W-1:0]    item_idx;
  logic                item_avail;
  logic [CREDIT_W-1:0] sum;

  function automatic logic [CREDIT_W-1:0] price(input logic [SEL_W-1:0] idx);
    return CREDIT_W'(BASE_PRICE) + CREDIT_W'(PRICE_STEP) * CREDIT_W'(idx);
  endfunction

  // Simultaneous coins: only the most valuable one counts.
  always_comb begin
    coin_val = '0;
    if (quarter_in)     coin_val = CREDIT_W'(5);
    else if (dime_in)   coin_val = CREDIT_W'(2);
    else if (nickel_in) coin_val = CREDIT_W'(1);
  end

  assign coin_seen   = nickel_in | dime_in | quarter_in;
  assign item_onehot = (item_number != '0) &&
                       ((item_number & (item_number - NUM_ITEMS'(1))) == '0);
  assign sum         = credit + coin_val;

  always_comb begin
    item_idx = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (item_number[i]) item_idx = SEL_W'(i);
  end

`ifdef VEND_STOCK_EN
  logic [STOCK_W-1:0] stock [NUM_ITEMS];

  assign item_avail = (stock[item_idx] != '0);

  // Restock overrides the decrement of the item leaving VEND in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock[i]    <= STOCK_W'(STOCK_INIT);
        sold_out[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (restock) begin
          stock[i]    <= STOCK_W'(STOCK_INIT);
          sold_out[i] <= (STOCK_INIT == 0);
        end else if (state == VEND && sel == SEL_W'(i) && stock[i] != '0) begin
          stock[i]    <= stock[i] - STOCK_W'(1);
          sold_out[i] <= (stock[i] == STOCK_W'(1));
        end
      end
    end
  end
`else
  logic unused_stock_cfg;

  assign item_avail       = 1'b1;
  assign sold_out         = '0;
  assign unused_stock_cfg = restock | (STOCK_W == 0) | (STOCK_INIT == 0);
`endif

  // Outputs are registered by setting them from the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      credit     <= '0;
      refund     <= '0;
      sel        <= '0;
      dispense   <= 1'b0;
      nickel_out <= 1'b0;
      coin_ready <= 1'b1;
    end else begin
      dispense   <= 1'b0;
      nickel_out <= 1'b0;
      coin_ready <= 1'b1;
      case (state)
        IDLE: begin
          if (coin_seen) begin
            sel <= item_idx;
            if (!item_onehot || !item_avail) begin
              refund     <= coin_val;
              state      <= CHANGE;
              nickel_out <= 1'b1;
              coin_ready <= 1'b0;
            end else begin
              credit <= coin_val;
              if (coin_val >= price(item_idx)) begin
                state      <= VEND;
                dispense   <= 1'b1;
                coin_ready <= 1'b0;
              end else begin
                state <= COLLECT;
              end
            end
          end
        end
        COLLECT: begin
          if (cancel) begin
            credit     <= '0;
            refund     <= sum;
            state      <= CHANGE;
            nickel_out <= 1'b1;
            coin_ready <= 1'b0;
          end else if (coin_seen) begin
            credit <= sum;
            if (sum >= price(sel)) begin
              state      <= VEND;
              dispense   <= 1'b1;
              coin_ready <= 1'b0;
            end
          end
        end
        VEND: begin
          credit <= '0;
          if (credit > price(sel)) begin
            refund     <= credit - price(sel);
            state      <= CHANGE;
            nickel_out <= 1'b1;
            coin_ready <= 1'b0;
          end else begin
            refund <= '0;
            state  <= IDLE;
          end
        end
        CHANGE: begin
          if (refund == CREDIT_W'(1)) begin
            refund <= '0;
            state  <= IDLE;
          end else begin
            refund     <= refund - CREDIT_W'(1);
            nickel_out <= 1'b1;
            coin_ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vend_credit_fsm.sv
// Self-checking bench for vend_credit_fsm: directed test-plan scenarios followed by random
// stimulus, all compared every cycle against a transaction-level reference model.
module tb_vend_credit_fsm;
  localparam int NUM_ITEMS  = 4;
  localparam int BASE_PRICE = 3;
  localparam int PRICE_STEP = 1;
  localparam int CREDIT_W   = 4;
  localparam int STOCK_W    = 4;
  localparam int STOCK_INIT = 1;
`ifdef VEND_STOCK_EN
  localparam bit STOCK_EN = 1'b1;
`else
  localparam bit STOCK_EN = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NUM_ITEMS-1:0] item_number;
  logic                 nickel_in, dime_in, quarter_in, cancel, restock;
  logic                 coin_ready, dispense, nickel_out;
  logic [CREDIT_W-1:0]  credit;
  logic [NUM_ITEMS-1:0] sold_out;

  always #5 clock = ~clock;

  vend_credit_fsm #(
    .NUM_ITEMS(NUM_ITEMS), .BASE_PRICE(BASE_PRICE), .PRICE_STEP(PRICE_STEP),
    .CREDIT_W(CREDIT_W), .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)
  ) dut (
    .clock(clock), .reset(reset), .item_number(item_number),
    .nickel_in(nickel_in), .dime_in(dime_in), .quarter_in(quarter_in),
    .cancel(cancel), .restock(restock), .coin_ready(coin_ready),
    .dispense(dispense), .nickel_out(nickel_out), .credit(credit), .sold_out(sold_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: money held, nickels still owed, and whether an item is about to drop.
  int m_credit;
  int m_owed;
  int m_sel;
  bit m_vend;
  bit m_collect;
  int m_stock [NUM_ITEMS];
  int disp_cnt;
  int nick_cnt;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int priceOf(input int idx);
    return BASE_PRICE + idx * PRICE_STEP;
  endfunction

  task automatic modelStep(input bit r, input logic [NUM_ITEMS-1:0] item,
                           input bit n, input bit d, input bit q, input bit c, input bit rs);
    int v;
    if (r) begin
      m_credit = 0; m_owed = 0; m_sel = 0; m_vend = 0; m_collect = 0;
      for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_INIT;
      return;
    end
    v = q ? 5 : d ? 2 : n ? 1 : 0;
    if (m_vend) begin
      if (STOCK_EN && m_stock[m_sel] > 0) m_stock[m_sel]--;
      m_owed   = m_credit - priceOf(m_sel);
      m_credit = 0;
      m_vend   = 0;
    end else if (m_owed > 0) begin
      m_owed--;
    end else if (m_collect) begin
      m_credit += v;
      if (c) begin
        m_owed = m_credit; m_credit = 0; m_collect = 0;
      end else if (m_credit >= priceOf(m_sel)) begin
        m_vend = 1; m_collect = 0;
      end
    end else if (v > 0) begin
      for (int i = 0; i < NUM_ITEMS; i++) if (item[i]) m_sel = i;
      if ($countones(item) != 1 || (STOCK_EN && m_stock[m_sel] == 0)) begin
        m_owed = v;
      end else begin
        m_credit = v;
        if (v >= priceOf(m_sel)) m_vend = 1;
        else m_collect = 1;
      end
    end
    if (STOCK_EN && rs)
      for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_INIT;
  endtask

  task automatic applyStimulus(input bit r, input logic [NUM_ITEMS-1:0] item,
                               input bit n, input bit d, input bit q, input bit c, input bit rs);
    reset = r; item_number = item; nickel_in = n; dime_in = d; quarter_in = q;
    cancel = c; restock = rs;
    @(posedge clock);
    modelStep(r, item, n, d, q, c, rs);
    #1;
    checkOutput("dispense", dispense, m_vend);
    checkOutput("nickel_out", nickel_out, m_owed > 0);
    checkOutput("credit", credit, m_credit);
    checkOutput("coin_ready", coin_ready, !m_vend && m_owed == 0);
    for (int i = 0; i < NUM_ITEMS; i++)
      checkOutput("sold_out", sold_out[i], STOCK_EN && m_stock[i] == 0);
    disp_cnt += dispense;
    nick_cnt += nickel_out;
  endtask

  task automatic idleCycles(input int count);
    for (int i = 0; i < count; i++) applyStimulus(0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic startScenario();
    applyStimulus(0, '0, 0, 0, 0, 0, 1);
    disp_cnt = 0;
    nick_cnt = 0;
  endtask

  task automatic endScenario(input string tag, input int exp_disp, input int exp_nick);
    idleCycles(10);
    checkOutput({tag, "_dispense_count"}, disp_cnt, exp_disp);
    checkOutput({tag, "_nickel_count"}, nick_cnt, exp_nick);
    checkOutput({tag, "_credit_end"}, credit, 0);
    checkOutput({tag, "_ready_end"}, coin_ready, 1);
  endtask

  initial begin
    logic [NUM_ITEMS-1:0] item;
    disp_cnt = 0;
    nick_cnt = 0;
    applyStimulus(1, '0, 0, 0, 0, 0, 0);
    applyStimulus(1, 4'b0001, 1, 1, 1, 1, 1);
    checkOutput("reset_ready", coin_ready, 1);
    checkOutput("reset_credit", credit, 0);

    startScenario();
    applyStimulus(0, 4'b0001, 0, 1, 0, 0, 0);
    applyStimulus(0, 4'b0001, 1, 0, 0, 0, 0);
    checkOutput("s1_dispense_after_nickel", dispense, 1);
    endScenario("s1", 1, 0);

    startScenario();
    applyStimulus(0, 4'b0001, 0, 0, 1, 0, 0);
    checkOutput("s2_dispense_after_quarter", dispense, 1);
    checkOutput("s2_ready_low", coin_ready, 0);
    applyStimulus(0, 4'b0001, 0, 1, 0, 0, 0);
    endScenario("s2", 1, 2);

    startScenario();
    applyStimulus(0, 4'b1000, 0, 1, 0, 0, 0);
    applyStimulus(0, 4'b1000, 1, 0, 0, 1, 0);
    checkOutput("s3_first_nickel", nickel_out, 1);
    endScenario("s3", 0, 3);

    startScenario();
    applyStimulus(0, 4'b0011, 0, 0, 1, 0, 0);
    endScenario("s4", 0, 5);

    startScenario();
    applyStimulus(0, 4'b0010, 1, 1, 1, 0, 0);
    endScenario("s5", 1, 1);

    if (STOCK_EN) begin
      startScenario();
      applyStimulus(0, 4'b0100, 0, 0, 1, 0, 0);
      endScenario("s6a", 1, 0);
      checkOutput("s6_sold_out_set", sold_out[2], 1);
      disp_cnt = 0;
      nick_cnt = 0;
      applyStimulus(0, 4'b0100, 0, 0, 1, 0, 0);
      endScenario("s6b", 0, 5);
      applyStimulus(0, '0, 0, 0, 0, 0, 1);
      checkOutput("s6_sold_out_cleared", sold_out[2], 0);
    end

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0) item = NUM_ITEMS'($urandom);
      else item = NUM_ITEMS'(1) << $urandom_range(0, NUM_ITEMS - 1);
      applyStimulus($urandom_range(0, 299) == 0, item,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 59) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
